pc_gen: RTL and testbench

Parametrised program-counter generator for the instruction-fetch stage; successor to the fixed 32-bit, increment-only PC register. Produces the fetch address and instruction-memory chip enable. Adds pipeline stall, branch redirect, exception/flush redirect, buffering of a branch that arrives during a stall, and a misalignment flag. Sits between the pipeline control unit and instruction ROM/cache, with branch inputs driven from ID.

---
 rtl/pc_gen_pkg.sv | 18 +
 rtl/pc_redirect_buf.sv | 34 +++
 rtl/pc_gen.sv | 126 ++++++++++++
 tb/tb_pc_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the instruction-fetch PC generator.
//   - pc_state_e      : FSM state encodings (OFF / RUN / HOLD)
//   - PC_EN / PC_DIS  : enable / disable constants for ce and hold
//   - PC_DEFAULT_RESET_VEC : default first fetch address after reset
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_OFF  = 2'd0,
    PC_RUN  = 2'd1,
    PC_HOLD = 2'd2
  } pc_state_e;

  localparam logic PC_EN  = 1'b1;
  localparam logic PC_DIS = 1'b0;

  localparam logic [31:0] PC_DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry buffer holding a taken branch that arrived
// while the fetch stage was stalled.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   capture       : load capture_addr and set valid (wins over clear)
//   clear         : drop the buffered entry
//   capture_addr  : branch target to buffer
//   valid, addr   : buffered entry
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] capture_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (capture) begin
      // A later capture simply overwrites an earlier one.
      valid <= 1'b1;
      addr  <= capture_addr;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the instruction-fetch stage.
// Produces the fetch address (pc) and instruction-memory chip enable (ce),
// with stall, branch redirect, flush redirect and a misalignment flag.
// Optional feature macro: PC_BRANCH_BUF_EN -- when defined, a branch seen
// during a stall is buffered and applied on the first non-stalled edge;
// when undefined, such a branch is ignored (upstream must hold it).
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   stall                   : hold pc
//   flush, flush_pc         : exception/flush redirect (overrides stall)
//   branch_flag, branch_target : taken branch from ID
//   pc                      : current fetch address
//   ce                      : instruction-memory chip enable
//   hold                    : high while in HOLD state
//   misalign                : pc low log2(INC) bits non-zero
// Interface handshake: there is no valid/ready pair here; every input is
// sampled on each rising edge and all outputs are registered, so nothing
// on the inputs reaches the outputs combinationally. ce together with
// hold fully exposes the FSM state (ce=0 OFF, hold=1 HOLD, else RUN).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_DEFAULT_RESET_VEC),
  parameter int unsigned       INC       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              hold,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);
  // INC is a power of two, so INC-1 masks exactly the low log2(INC) bits;
  // for INC=1 the mask is zero and misalign is constantly 0.
  localparam logic [ADDR_W-1:0] MASK  = INC_V - ADDR_W'(1);

  pc_state_e         state;
  logic              running;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] pc_next;

  assign running = (state != PC_OFF);

`ifdef PC_BRANCH_BUF_EN
  logic buf_capture;
  logic buf_clear;

  assign buf_capture = running & ~flush & stall & branch_flag;
  // Any non-stalled edge consumes or discards the entry; flush discards it.
  assign buf_clear   = running & (flush | ~stall);

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_redirect_buf (
    .clk         (clk),
    .rst         (rst),
    .capture     (buf_capture),
    .clear       (buf_clear),
    .capture_addr(branch_target),
    .valid       (pend_valid),
    .addr        (pend_addr)
  );
`else
  assign pend_valid = 1'b0;
  assign pend_addr  = '0;
`endif

  // Next fetch address in strict priority: flush, stall, live branch,
  // buffered branch, sequential. OFF leaves pc untouched so RESET_VEC is
  // the first address fetched.
  always_comb begin
    pc_next = pc;
    if (running) begin
      if (flush) begin
        pc_next = flush_pc;
      end else if (stall) begin
        pc_next = pc;
      end else if (branch_flag) begin
        pc_next = branch_target;
      end else if (pend_valid) begin
        pc_next = pend_addr;
      end else begin
        pc_next = pc + INC_V;   // wraps modulo 2^ADDR_W
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PC_OFF;
      pc       <= RESET_VEC;
      ce       <= PC_DIS;
      hold     <= PC_DIS;
      misalign <= |(RESET_VEC & MASK);
    end else begin
      pc       <= pc_next;
      misalign <= |(pc_next & MASK);
      ce       <= PC_EN;
      case (state)
        PC_OFF: begin
          state <= PC_RUN;
          hold  <= PC_DIS;
        end
        default: begin
          if (!flush && stall) begin
            state <= PC_HOLD;
            hold  <= PC_EN;
          end else begin
            state <= PC_RUN;
            hold  <= PC_DIS;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed testbench for pc_gen. Two instances share stimulus:
// dut_a with default RESET_VEC=0, dut_b with RESET_VEC=0xFFFFFFF8 to cover
// address wrap. A behavioural model is checked every cycle, and literal
// hand-computed expectations pin the model.
module tb_pc_gen;

`ifdef PC_BRANCH_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        stall, flush, branch_flag;
  logic [31:0] flush_pc, branch_target;

  logic [31:0] pc_a, pc_b;
  logic        ce_a, ce_b, hold_a, hold_b, mis_a, mis_b;

  pc_gen #(.ADDR_W(32), .RESET_VEC(RV0), .INC(4)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .pc(pc_a), .ce(ce_a), .hold(hold_a), .misalign(mis_a)
  );

  pc_gen #(.ADDR_W(32), .RESET_VEC(RV1), .INC(4)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .pc(pc_b), .ce(ce_b), .hold(hold_b), .misalign(mis_b)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: fetching enabled?, current pc, stalled last edge?,
  // and the buffered branch (if any).
  logic        m_on   [2];
  logic [31:0] m_pc   [2];
  logic        m_hold [2];
  logic        m_pv   [2];
  logic [31:0] m_pa   [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_on[i]   <= 1'b0;
        m_pc[i]   <= (i == 0) ? RV0 : RV1;
        m_hold[i] <= 1'b0;
        m_pv[i]   <= 1'b0;
        m_pa[i]   <= 32'h0;
      end else if (!m_on[i]) begin
        m_on[i] <= 1'b1;
      end else if (flush) begin
        m_pc[i] <= flush_pc;  m_pv[i] <= 1'b0;  m_hold[i] <= 1'b0;
      end else if (stall) begin
        m_hold[i] <= 1'b1;
        if (BUF && branch_flag) begin
          m_pv[i] <= 1'b1;  m_pa[i] <= branch_target;
        end
      end else if (branch_flag) begin
        m_pc[i] <= branch_target;  m_pv[i] <= 1'b0;  m_hold[i] <= 1'b0;
      end else if (m_pv[i]) begin
        m_pc[i] <= m_pa[i];  m_pv[i] <= 1'b0;  m_hold[i] <= 1'b0;
      end else begin
        m_pc[i] <= m_pc[i] + 32'd4;  m_hold[i] <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("model_pc_a",   pc_a,         m_pc[0]);
    chk("model_ce_a",   32'(ce_a),    32'(m_on[0]));
    chk("model_hold_a", 32'(hold_a),  32'(m_hold[0]));
    chk("model_mis_a",  32'(mis_a),   32'(m_pc[0][1:0] != 2'b00));
    chk("model_pc_b",   pc_b,         m_pc[1]);
    chk("model_ce_b",   32'(ce_b),    32'(m_on[1]));
    chk("model_hold_b", 32'(hold_b),  32'(m_hold[1]));
    chk("model_mis_b",  32'(mis_b),   32'(m_pc[1][1:0] != 2'b00));
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic s, input logic f, input logic [31:0] fpc,
                     input logic b, input logic [31:0] bt);
    stall = s;  flush = f;  flush_pc = fpc;  branch_flag = b;  branch_target = bt;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    stall = 1'b0;  flush = 1'b0;  flush_pc = 32'h0;
    branch_flag = 1'b0;  branch_target = 32'h0;
    @(negedge clk);
    chk("rst_pc_a",   pc_a, 32'h0);
    chk("rst_ce_a",   32'(ce_a), 32'd0);
    chk("rst_hold_a", 32'(hold_a), 32'd0);
    chk("rst_pc_b",   pc_b, 32'hFFFF_FFF8);

    // Release reset; branch during OFF must be ignored.
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h900);
    chk("first_ce_a", 32'(ce_a), 32'd1);
    chk("first_pc_a", pc_a, 32'h0);
    chk("first_pc_b", pc_b, 32'hFFFF_FFF8);
    idle();
    chk("seq_pc_a_4", pc_a, 32'h4);
    chk("seq_pc_b_fc", pc_b, 32'hFFFF_FFFC);
    idle();
    chk("seq_pc_a_8", pc_a, 32'h8);
    chk("wrap_pc_b_0", pc_b, 32'h0);

    // Branch redirect.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    chk("br_pc_100", pc_a, 32'h100);
    idle();
    chk("br_pc_104", pc_a, 32'h104);

    // Stall 3 cycles, branch on the 2nd stalled cycle.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_pc_held", pc_a, 32'h104);
    chk("stall_hold", 32'(hold_a), 32'd1);
    chk("stall_ce", 32'(ce_a), 32'd1);
    idle();
    chk("release_pc", pc_a, BUF ? 32'h200 : 32'h108);
    chk("release_hold", 32'(hold_a), 32'd0);

    // Flush overrides stall and discards the pending branch.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
    cyc(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    chk("flush_pc_80", pc_a, 32'h80);
    chk("flush_hold", 32'(hold_a), 32'd0);
    idle();
    chk("flush_discard", pc_a, 32'h84);

    // Live branch on the release edge wins over the buffered one.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h400);
    chk("live_wins", pc_a, 32'h400);
    idle();
    chk("live_after", pc_a, 32'h404);

    // Misaligned branch target.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
    chk("mis_pc", pc_a, 32'h102);
    chk("mis_flag_a", 32'(mis_a), 32'd1);
    chk("mis_flag_b", 32'(mis_b), 32'd1);
    idle();
    chk("mis_seq", pc_a, 32'h106);

    // Flush beats a simultaneous branch.
    cyc(1'b0, 1'b1, 32'h40, 1'b1, 32'h50);
    chk("flush_over_br", pc_a, 32'h40);
    chk("flush_mis", 32'(mis_a), 32'd0);

    // Later capture overwrites earlier one.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h500);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h600);
    idle();
    chk("overwrite_pc", pc_a, BUF ? 32'h600 : 32'h44);

    // Asynchronous reset in the middle of HOLD.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h700);
    chk("pre_rst_hold", 32'(hold_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc_a", pc_a, 32'h0);
    chk("async_rst_ce_a", 32'(ce_a), 32'd0);
    chk("async_rst_hold_a", 32'(hold_a), 32'd0);
    chk("async_rst_pc_b", pc_b, 32'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("rerun_ce", 32'(ce_a), 32'd1);
    chk("rerun_pc_0", pc_a, 32'h0);
    idle();
    chk("rerun_pc_4", pc_a, 32'h4);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
